handshake_fifo_break_dv: RTL and testbench

//  Elastic FIFO buffer on a 14-bit dataflow channel. It sits directly downstream of
//  the constant generators and operators in the Dynamatic-generated handshake netlist.
//  It breaks the combinational valid/data path and the ready path between producer and

---
 rtl/handshake_fifo_break_dv.sv | 72 +++++++
 tb/tb_handshake_fifo_break_dv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_break_dv.sv
// Elastic token FIFO for a valid/ready dataflow channel. Valid, data and ready are
// all driven from registers, so the producer and consumer timing paths are decoupled.
module handshake_fifo_break_dv #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_SLOTS  = 4,
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1),
    localparam int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_SLOTS - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(NUM_SLOTS));
    assign w_empty = (r_count == '0);

    assign ins_ready  = !w_full;
    assign outs_valid = !w_empty;
    assign outs       = r_mem[r_head];
    assign occupancy  = r_count;

    assign w_push = ins_valid  & ins_ready;
    assign w_pop  = outs_valid & outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= ins;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop)
                r_head <= ptr_inc(r_head);
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_fifo_break_dv.sv
// Scoreboard bench for handshake_fifo_break_dv: a 4-slot instance for directed
// scenarios and a 3-slot instance for randomized wrap-around traffic.
module tb_handshake_fifo_break_dv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] ins4, outs4, ins3, outs3;
    logic        ins_valid4, ins_ready4, outs_valid4, outs_ready4;
    logic        ins_valid3, ins_ready3, outs_valid3, outs_ready3;
    logic [2:0]  occ4;
    logic [1:0]  occ3;

    handshake_fifo_break_dv #(.DATA_WIDTH(14), .NUM_SLOTS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
        .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4),
        .occupancy(occ4)
    );

    handshake_fifo_break_dv #(.DATA_WIDTH(14), .NUM_SLOTS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
        .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3),
        .occupancy(occ3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int sent3    = 0;
    logic [13:0] q4[$];
    logic [13:0] q3[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (outs_valid4 && outs_ready4) begin
                check_eq("pop_nonempty4", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) check_eq("data4", 32'(outs4), 32'(q4.pop_front()));
            end
            if (ins_valid4 && ins_ready4) q4.push_back(ins4);
            if (outs_valid3 && outs_ready3) begin
                check_eq("pop_nonempty3", 32'(q3.size() != 0), 32'd1);
                if (q3.size() != 0) check_eq("data3", 32'(outs3), 32'(q3.pop_front()));
            end
            if (ins_valid3 && ins_ready3) begin
                q3.push_back(ins3);
                sent3++;
            end
        end
    end

    initial begin
        int guard;
        ins4 = '0; ins_valid4 = 1'b0; outs_ready4 = 1'b0;
        ins3 = '0; ins_valid3 = 1'b0; outs_ready3 = 1'b0;

        // 1: reset
        rst = 1'b0;
        repeat (3) step();
        check_eq("rst_outs_valid_held", 32'(outs_valid4), 32'd0);
        rst = 1'b1;
        step();
        check_eq("rst_outs_valid", 32'(outs_valid4), 32'd0);
        check_eq("rst_ins_ready",  32'(ins_ready4),  32'd1);
        check_eq("rst_occ",        32'(occ4),        32'd0);
        check_eq("rst_outs",       32'(outs4),       32'd0);
        check_eq("rst_ins_ready3", 32'(ins_ready3),  32'd1);

        // 2: single token with one cycle latency
        ins4 = 14'h3DA5; ins_valid4 = 1'b1; outs_ready4 = 1'b1;
        step();
        ins_valid4 = 1'b0; ins4 = '0;
        check_eq("single_valid", 32'(outs_valid4), 32'd1);
        check_eq("single_data",  32'(outs4),       32'h3DA5);
        step();
        check_eq("single_popped", 32'(outs_valid4), 32'd0);
        check_eq("single_occ",    32'(occ4),        32'd0);

        // 3: fill to full, then drain in order
        outs_ready4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ins4 = 14'(i); ins_valid4 = 1'b1;
            step();
            check_eq("fill_occ", 32'(occ4), 32'(i));
        end
        check_eq("full_ins_ready", 32'(ins_ready4), 32'd0);
        ins4 = 14'd5;
        repeat (2) step();
        check_eq("full_hold_occ",  32'(occ4),  32'd4);
        check_eq("full_hold_head", 32'(outs4), 32'd1);
        ins_valid4 = 1'b0;
        outs_ready4 = 1'b1;
        step();
        check_eq("unfull_ins_ready", 32'(ins_ready4), 32'd1);
        check_eq("unfull_occ",       32'(occ4),       32'd3);
        guard = 0;
        while (outs_valid4 && guard < 10) begin step(); guard++; end
        check_eq("drain_done", 32'(outs_valid4), 32'd0);
        check_eq("drain_q4",   32'(q4.size()),   32'd0);

        // 4: streaming at full rate
        outs_ready4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ins4 = 14'(i); ins_valid4 = 1'b1;
            step();
            check_eq("stream_occ", 32'(occ4), 32'd1);
        end
        ins_valid4 = 1'b0;
        step();
        check_eq("stream_empty", 32'(occ4),      32'd0);
        check_eq("stream_q4",    32'(q4.size()), 32'd0);

        // 5: random traffic through the 3-slot instance
        guard = 0;
        while (sent3 < 1000 && guard < 20000) begin
            ins3        = 14'($urandom);
            ins_valid3  = 1'($urandom_range(0, 1));
            outs_ready3 = 1'($urandom_range(0, 1));
            step();
            check_eq("rand_occ3", 32'(occ3), 32'(q3.size()));
            guard++;
        end
        check_eq("rand_sent_all", 32'(sent3 >= 1000), 32'd1);
        ins_valid3 = 1'b0; outs_ready3 = 1'b1;
        guard = 0;
        while (outs_valid3 && guard < 10) begin step(); guard++; end
        check_eq("rand_drained", 32'(outs_valid3), 32'd0);
        check_eq("rand_q3",      32'(q3.size()),   32'd0);
        outs_ready3 = 1'b0;

        // 6: asynchronous reset with three tokens stored
        outs_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins4 = 14'h100 + 14'(i); ins_valid4 = 1'b1;
            step();
        end
        ins_valid4 = 1'b0;
        check_eq("pre_rst_occ", 32'(occ4), 32'd3);
        #2;
        rst = 1'b0;
        q4.delete();
        #1;
        check_eq("async_outs_valid", 32'(outs_valid4), 32'd0);
        check_eq("async_occ",        32'(occ4),        32'd0);
        step();
        rst = 1'b1;
        step();
        check_eq("post_rst_occ",   32'(occ4),       32'd0);
        check_eq("post_rst_outs",  32'(outs4),      32'd0);
        check_eq("post_rst_ready", 32'(ins_ready4), 32'd1);
        outs_ready4 = 1'b1;
        repeat (3) begin
            step();
            check_eq("no_stale_valid", 32'(outs_valid4), 32'd0);
        end
        ins4 = 14'h2A5A; ins_valid4 = 1'b1;
        step();
        ins_valid4 = 1'b0;
        check_eq("post_rst_token", 32'(outs4), 32'h2A5A);
        step();
        check_eq("post_rst_q4", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
